// File: rtl/step_sequencer.sv
// step_sequencer: walks a one-hot step bus 0001 -> 0010 -> 0100 -> 1000 using a
// tick prescaler. Step 1000 waits for the cronometer's done pulse or a timeout.
// The block counts laps and stops after LAPS laps (LAPS=0 runs forever).
// A pause freezes all timing; a done pulse that arrives while paused in 1000 is
// remembered and consumed once sequencing resumes.
module step_sequencer #(
   parameter int TICK_DIV = 25_000_000,
   parameter int DWELL    = 3,
   parameter int TIMEOUT  = 8,
   parameter int LAPS     = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_done_in,
   output logic [3:0] o_step,
   output logic       o_busy,
   output logic [7:0] o_lap_count,
   output logic       o_seq_done,
   output logic       o_timeout
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DWELL + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_WAIT_DONE,
      S_HOLD
   } state_t;

   state_t        r_state;
   state_t        r_saved_state;
   logic [3:0]    r_step;
   logic          r_busy;
   logic [7:0]    r_lap_count;
   logic          r_seq_done;
   logic          r_timeout;
   logic [PW-1:0] r_presc;
   logic [DW-1:0] r_dwell;
   logic [TW-1:0] r_tmo;
   logic          r_pending;

   logic          w_tick;
   logic          w_done_eff;
   logic [7:0]    w_lap_inc;
   logic          w_last_lap;

   // The prescaler only advances while actively sequencing, so a tick can only
   // occur in RUN or WAIT_DONE.
   assign w_tick     = ((r_state == S_RUN) || (r_state == S_WAIT_DONE)) && (r_presc == PRESC_LAST);
   // A done pulse remembered during a pause counts as a fresh done_in.
   assign w_done_eff = i_done_in | r_pending;
   // Lap counter saturates rather than wrapping.
   assign w_lap_inc  = (r_lap_count == 8'hFF) ? 8'hFF : r_lap_count + 8'd1;
   assign w_last_lap = (LAPS != 0) && (int'(w_lap_inc) == LAPS);

   // Sequencer FSM with all outputs and counters registered.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state       <= S_IDLE;
         r_saved_state <= S_IDLE;
         r_step        <= 4'b0000;
         r_busy        <= 1'b0;
         r_lap_count   <= 8'd0;
         r_seq_done    <= 1'b0;
         r_timeout     <= 1'b0;
         r_presc       <= '0;
         r_dwell       <= '0;
         r_tmo         <= '0;
         r_pending     <= 1'b0;
      end else begin
         r_seq_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state     <= S_RUN;
                  r_step      <= 4'b0001;
                  r_busy      <= 1'b1;
                  r_lap_count <= 8'd0;
                  r_timeout   <= 1'b0;
                  r_presc     <= '0;
                  r_dwell     <= '0;
                  r_tmo       <= '0;
                  r_pending   <= 1'b0;
               end
            end
            S_RUN: begin
               if (i_pause) begin
                  r_saved_state <= S_RUN;
                  r_state       <= S_HOLD;
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (r_dwell == DWELL_LAST) begin
                     r_dwell <= '0;
                     r_step  <= {r_step[2:0], 1'b0};
                     if (r_step[2]) begin
                        r_state <= S_WAIT_DONE;
                     end
                  end else begin
                     r_dwell <= r_dwell + DW'(1);
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            S_WAIT_DONE: begin
               if (i_pause) begin
                  // A done pulse coinciding with the pause is kept, not dropped.
                  r_saved_state <= S_WAIT_DONE;
                  r_state       <= S_HOLD;
                  if (i_done_in) begin
                     r_pending <= 1'b1;
                  end
               end else if (w_done_eff) begin
                  r_pending   <= 1'b0;
                  r_presc     <= '0;
                  r_dwell     <= '0;
                  r_tmo       <= '0;
                  r_lap_count <= w_lap_inc;
                  if (w_last_lap) begin
                     r_step     <= 4'b0000;
                     r_busy     <= 1'b0;
                     r_seq_done <= 1'b1;
                     r_state    <= S_IDLE;
                  end else begin
                     r_step  <= 4'b0001;
                     r_state <= S_RUN;
                  end
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (r_tmo == TMO_LAST) begin
                     r_tmo     <= '0;
                     r_timeout <= 1'b1;
                     r_step    <= 4'b0000;
                     r_busy    <= 1'b0;
                     r_state   <= S_IDLE;
                  end else begin
                     r_tmo <= r_tmo + TW'(1);
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end
            S_HOLD: begin
               if (i_done_in && (r_saved_state == S_WAIT_DONE)) begin
                  r_pending <= 1'b1;
               end
               if (!i_pause) begin
                  r_state <= r_saved_state;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_step      = r_step;
   assign o_busy      = r_busy;
   assign o_lap_count = r_lap_count;
   assign o_seq_done  = r_seq_done;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus randomized stimulus, all
// checked every cycle against a time-in-step reference model. A second
// instance with LAPS=0 checks lap saturation.
module tb_step_sequencer;

   localparam int TD = 4;
   localparam int DW = 2;
   localparam int TO = 3;
   localparam int LP = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, pause = 1'b0, done = 1'b0;
   logic       start_b = 1'b0, pause_b = 1'b0, done_b = 1'b0;
   logic [3:0] step, step_b;
   logic       busy, busy_b, seqd, seqd_b, tmo, tmo_b;
   logic [7:0] lap, lap_b;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: position in the 4-step cycle plus the number of
   // un-paused cycles spent in the current step.
   bit m_active, m_hold, m_pend, m_seqd, m_tmo;
   int m_pos, m_cnt, m_lap;

   step_sequencer #(.TICK_DIV(TD), .DWELL(DW), .TIMEOUT(TO), .LAPS(LP)) dut_a (
      .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_pause(pause), .i_done_in(done),
      .o_step(step), .o_busy(busy), .o_lap_count(lap), .o_seq_done(seqd), .o_timeout(tmo)
   );

   step_sequencer #(.TICK_DIV(TD), .DWELL(DW), .TIMEOUT(TO), .LAPS(0)) dut_b (
      .i_clk(clk), .i_rst(rst_n), .i_start(start_b), .i_pause(pause_b), .i_done_in(done_b),
      .o_step(step_b), .o_busy(busy_b), .o_lap_count(lap_b), .o_seq_done(seqd_b), .o_timeout(tmo_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      if (!rst_n) begin
         m_active = 0; m_hold = 0; m_pend = 0; m_seqd = 0; m_tmo = 0;
         m_pos = 0; m_cnt = 0; m_lap = 0;
      end else begin
         m_seqd = 0;
         if (!m_active) begin
            if (start) begin
               m_active = 1; m_hold = 0; m_pend = 0; m_tmo = 0;
               m_pos = 0; m_cnt = 0; m_lap = 0;
            end
         end else if (m_hold) begin
            if (done && m_pos == 3) m_pend = 1;
            if (!pause) m_hold = 0;
         end else if (pause) begin
            m_hold = 1;
            if (done && m_pos == 3) m_pend = 1;
         end else if (m_pos == 3 && (done || m_pend)) begin
            m_pend = 0;
            m_cnt = 0;
            m_lap = (m_lap < 255) ? m_lap + 1 : 255;
            if (LP != 0 && m_lap == LP) begin
               m_active = 0;
               m_seqd = 1;
            end else begin
               m_pos = 0;
            end
         end else begin
            m_cnt++;
            if (m_pos < 3 && m_cnt == DW * TD) begin
               m_pos++;
               m_cnt = 0;
            end else if (m_pos == 3 && m_cnt == TO * TD) begin
               m_active = 0;
               m_tmo = 1;
            end
         end
      end
   endtask

   // One clock: advance the model with the inputs seen at the edge, then
   // compare every output of instance A shortly after the edge.
   task automatic cyc();
      @(posedge clk);
      model_update();
      #1;
      chk("step",     32'(step), m_active ? (32'd1 << m_pos) : 32'd0);
      chk("busy",     32'(busy), 32'(m_active));
      chk("lap",      32'(lap),  32'(m_lap));
      chk("seq_done", 32'(seqd), 32'(m_seqd));
      chk("timeout",  32'(tmo),  32'(m_tmo));
   endtask

   bit saw_seqd_b;
   int w;
   int rate;

   initial begin
      // 1: reset state, then mid-run reset
      rst_n = 1'b0;
      cyc(); cyc();
      chk("rst_step", 32'(step), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1; start = 1'b1; cyc(); start = 1'b0;
      repeat (10) cyc();
      rst_n = 1'b0; cyc();
      chk("midrst_step", 32'(step), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_lap",  32'(lap),  32'd0);
      chk("midrst_tmo",  32'(tmo),  32'd0);
      cyc(); rst_n = 1'b1; cyc();

      // 2: self-timed steps, 8 cycles each
      start = 1'b1; cyc(); start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         chk("selftimed_step", 32'(step), 32'd1 << (i / 8));
         cyc();
      end
      chk("enter_1000", 32'(step), 32'd8);

      // 3: two laps, done_in shortly after entering 1000
      cyc(); cyc();
      done = 1'b1; cyc(); done = 1'b0;
      chk("lap1_step", 32'(step), 32'd1);
      chk("lap1_cnt",  32'(lap),  32'd1);
      repeat (24) cyc();
      chk("lap2_enter", 32'(step), 32'd8);
      done = 1'b1; cyc(); done = 1'b0;
      chk("lap2_seqd", 32'(seqd), 32'd1);
      chk("lap2_step", 32'(step), 32'd0);
      chk("lap2_busy", 32'(busy), 32'd0);
      chk("lap2_cnt",  32'(lap),  32'd2);
      cyc();
      chk("seqd_pulse", 32'(seqd), 32'd0);

      // 4: timeout after 12 cycles in 1000, cleared by the next start
      start = 1'b1; cyc(); start = 1'b0;
      repeat (24) cyc();
      chk("tmo_enter", 32'(step), 32'd8);
      repeat (11) cyc();
      chk("tmo_before", 32'(tmo), 32'd0);
      cyc();
      chk("tmo_set",  32'(tmo),  32'd1);
      chk("tmo_step", 32'(step), 32'd0);
      chk("tmo_busy", 32'(busy), 32'd0);
      start = 1'b1; cyc(); start = 1'b0;
      chk("tmo_clear", 32'(tmo), 32'd0);
      chk("tmo_lap0",  32'(lap), 32'd0);

      // 5: pause in 1000 with done_in during pause
      repeat (24) cyc();
      chk("pause_enter", 32'(step), 32'd8);
      pause = 1'b1;
      for (int i = 0; i < 20; i++) begin
         done = (i == 5);
         cyc();
         chk("pause_hold", 32'(step), 32'd8);
      end
      done = 1'b0; pause = 1'b0;
      cyc();
      chk("pause_rel", 32'(step), 32'd8);
      cyc();
      chk("pause_lap_step", 32'(step), 32'd1);
      chk("pause_lap_cnt",  32'(lap),  32'd1);

      // 6: done_in on the final timeout tick wins
      repeat (24) cyc();
      repeat (11) cyc();
      done = 1'b1; cyc(); done = 1'b0;
      chk("race_lap",  32'(lap),  32'd2);
      chk("race_tmo",  32'(tmo),  32'd0);
      chk("race_seqd", 32'(seqd), 32'd1);

      // start and pause together in IDLE: run starts, then holds
      start = 1'b1; pause = 1'b1; cyc(); start = 1'b0;
      chk("sp_busy", 32'(busy), 32'd1);
      repeat (15) cyc();
      chk("sp_frozen", 32'(step), 32'd1);
      pause = 1'b0;
      repeat (30) cyc();

      // LAPS=0 instance: 300 laps saturate at 255, never seq_done
      saw_seqd_b = 1'b0;
      start_b = 1'b1; cyc(); start_b = 1'b0;
      for (int l = 0; l < 300; l++) begin
         w = 0;
         while (step_b !== 4'b1000 && w < 40) begin
            cyc();
            if (seqd_b === 1'b1) saw_seqd_b = 1'b1;
            w++;
         end
         chk("b_reach_1000", 32'(step_b), 32'd8);
         done_b = 1'b1; cyc(); done_b = 1'b0;
         if (seqd_b === 1'b1) saw_seqd_b = 1'b1;
      end
      chk("b_lap_sat",  32'(lap_b),      32'd255);
      chk("b_no_seqd",  32'(saw_seqd_b), 32'd0);
      chk("b_busy",     32'(busy_b),     32'd1);
      chk("b_step",     32'(step_b),     32'd1);

      // Randomized traffic against the model
      for (int seg = 0; seg < 6; seg++) begin
         rate = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 3 : 20);
         repeat (500) begin
            rst_n = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            done = ($urandom_range(0, 99) < rate);
            cyc();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
